register_file_core: RTL and testbench
=====================================

# register_file_core

Sequential 32 × 16-bit register file: the storage stage that holds the register array, decodes write addresses to one-hot, and feeds the one-hot word-replacement logic that forms each cycle's next register-file value. Provides:
- one write port with a valid/ready handshake;
- two registered read ports with same-cycle write bypass;
- a 32-cycle clear sweep that zeroes the array on command without a reset.

## Interface
Parameters:
- WORD_WIDTH, 16, bits per register
- NUM_REGS, 32, number of registers
- ADDR_WIDTH, 5, address width; address k selects register k+1 (registers are numbered 1..32)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- wr_valid  in  1  write request
- wr_ready  out  1  write port can accept; a write is accepted when wr_valid && wr_ready at a rising edge
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  WORD_WIDTH  write value
- clear_req  in  1  starts a clear sweep; sampled only in IDLE
- busy  out  1  clear sweep in progress
- rd_addr_a  in  ADDR_WIDTH  read address, port A
- rd_data_a  out  WORD_WIDTH  read data, port A; registered
- rd_addr_b  in  ADDR_WIDTH  read address, port B
- rd_data_b  out  WORD_WIDTH  read data, port B; registered

## Operation
States:
- IDLE
  - wr_ready=1, busy=0.
  - An accepted write replaces register wr_addr+1 with wr_data; all other registers hold.
  - If clear_req=1, go to CLEAR and set clr_cnt=0.
- CLEAR
  - wr_ready=0, busy=1; wr_valid is ignored.
  - Each cycle zeroes register clr_cnt+1, then increments clr_cnt.
  - When clr_cnt=31 is zeroed, return to IDLE.
  - clear_req is ignored in this state.

Simultaneous write and clear_req in IDLE: the write commits at that edge, and the sweep starts on the next cycle. The written value is therefore zeroed when the sweep reaches its register.

Next-state array:
- Formed by a one-hot merge. Write enable vector = decoded(wr_addr) AND accept; clear vector = decoded(clr_cnt) AND (state==CLEAR).
- The two vectors are never both active.

Read ports:
- Each rd_data_x captures the next-state value of register rd_addr_x+1. This gives bypass: reading the address being written in the same cycle returns wr_data, and reading the register being cleared returns 0.
- Ports A and B are independent. Both may read the same address.

Reset (asynchronous) sets:
- all registers = 0
- state = IDLE, clr_cnt = 0
- rd_data_a = rd_data_b = 0
- wr_ready = 1, busy = 0

Reset asserted mid-sweep aborts the sweep immediately. No partial state survives.

## Timing
- Write: accepted at edge N; the stored value is visible at edge N.
- Read: address presented in cycle N; data on rd_data_x after edge N (latency 1). Values include any write or clear committed at edge N.
- Clear: clear_req in IDLE at edge N.
  - busy=1 and wr_ready=0 from after edge N.
  - Registers 1..32 are zeroed at edges N+1..N+32.
  - busy=0 and wr_ready=1 after edge N+32.
- wr_ready and busy are Moore outputs, decoded from the state register only (no combinational path from inputs).
- clr_cnt wraps 31 → 0 on the CLEAR → IDLE transition.

## Structure
- Package reg_file_pkg:
  - constants WORD_WIDTH=16, NUM_REGS=32, ADDR_WIDTH=5
  - typedef word_t (logic [WORD_WIDTH:1])
  - typedef state_t enum {IDLE, CLEAR}
- Sub-module write_addr_decoder: ADDR_WIDTH → NUM_REGS one-hot with enable; bit k+1 is set for address k.
  - Instantiated twice: once for the write address, once for clr_cnt.
- Top level holds the array flops, FSM, clr_cnt, and the read-port flops.

## Test plan
- Reset: assert reset mid-cycle. Required: rd_data_a/b=0, wr_ready=1, busy=0 immediately; reading addresses 0..31 returns 0.
- Write/read: write 0xBEEF to addr 7 with wr_valid=1, then read A=7, B=6. Required: rd_data_a=0xBEEF, rd_data_b=0 one cycle later.
- Bypass: in one cycle write 0x1234 to addr 31 and set rd_addr_a=31. Required: rd_data_a=0x1234 after that edge.
- Clear: fill all registers with 0xFFFF, then pulse clear_req. Required:
  - busy high for exactly 32 cycles, with wr_valid blocked (a write to addr 3 during the sweep is not stored);
  - all registers read 0 afterwards.
- Write with clear_req: write 0x5555 to addr 0 together with clear_req=1. Required: reading addr 0 in the next cycle returns 0x5555, and returns 0 after the sweep completes.
- Reset mid-sweep: assert reset at sweep cycle 10. Required: busy=0 at once, all registers 0, and a new write to addr 2 is accepted immediately after reset release.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared constants and types for the 32 x 16-bit register file.
package reg_file_pkg;

    localparam int WORD_WIDTH = 16;
    localparam int NUM_REGS   = 32;
    localparam int ADDR_WIDTH = 5;

    typedef logic [WORD_WIDTH:1] word_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/register_file_core_write_addr_decoder.sv
// Address to one-hot decoder with enable; address k sets bit k+1.
module write_addr_decoder
    import reg_file_pkg::*;
(
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  en,
    output logic [NUM_REGS:1]     onehot
);

    // One-hot decode, all zero when not enabled
    always_comb begin
        onehot = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (en && (int'(addr) == k)) begin
                onehot[k + 1] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/register_file_core.sv
// Register file storage stage: array flops, write/clear one-hot merge,
// clear-sweep FSM and two registered read ports with write bypass.
//
// Write handshake: a write transfers on a rising edge where wr_valid and
// wr_ready are both high. wr_ready depends only on the FSM state (high in
// IDLE, low during a clear sweep), never on wr_valid or any other input.
module register_file_core
    import reg_file_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WORD_WIDTH-1:0] wr_data,
    input  logic                  clear_req,
    output logic                  busy,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    output logic [WORD_WIDTH-1:0] rd_data_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [WORD_WIDTH-1:0] rd_data_b
);

    state_t                state;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic                  accept;
    logic [NUM_REGS:1]     wr_en;
    logic [NUM_REGS:1]     clr_en;
    word_t                 regs      [1:NUM_REGS];
    word_t                 next_regs [1:NUM_REGS];
    word_t                 rd_next_a;
    word_t                 rd_next_b;

    assign accept = wr_valid && wr_ready;

    write_addr_decoder u_wr_dec (
        .addr   (wr_addr),
        .en     (accept),
        .onehot (wr_en)
    );

    write_addr_decoder u_clr_dec (
        .addr   (clr_cnt),
        .en     (state == CLEAR),
        .onehot (clr_en)
    );

    // One-hot merge: write or clear replaces a word, everything else holds.
    // Writes are only accepted in IDLE, so the two vectors never overlap.
    always_comb begin
        for (int k = 1; k <= NUM_REGS; k++) begin
            if (wr_en[k]) begin
                next_regs[k] = wr_data;
            end else if (clr_en[k]) begin
                next_regs[k] = '0;
            end else begin
                next_regs[k] = regs[k];
            end
        end
    end

    // Read muxes select from the next-state array to give same-cycle bypass
    always_comb begin
        rd_next_a = '0;
        rd_next_b = '0;
        for (int k = 1; k <= NUM_REGS; k++) begin
            if (int'(rd_addr_a) + 1 == k) begin
                rd_next_a = next_regs[k];
            end
            if (int'(rd_addr_b) + 1 == k) begin
                rd_next_b = next_regs[k];
            end
        end
    end

    // Sweep FSM with registered Moore outputs; clr_cnt wraps to 0 on exit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            clr_cnt  <= '0;
            wr_ready <= 1'b1;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        state    <= CLEAR;
                        clr_cnt  <= '0;
                        wr_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == ADDR_WIDTH'(NUM_REGS - 1)) begin
                        state    <= IDLE;
                        wr_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    clr_cnt  <= '0;
                    wr_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    // Register array update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 1; k <= NUM_REGS; k++) begin
                regs[k] <= '0;
            end
        end else begin
            for (int k = 1; k <= NUM_REGS; k++) begin
                regs[k] <= next_regs[k];
            end
        end
    end

    // Read-port output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_a <= '0;
            rd_data_b <= '0;
        end else begin
            rd_data_a <= rd_next_a;
            rd_data_b <= rd_next_b;
        end
    end

endmodule

// File: tb/tb_register_file_core.sv
// Directed bench for register_file_core: reset, write/read, bypass,
// clear sweep, write coinciding with clear_req, and reset mid-sweep.
module tb_register_file_core;

    logic        clk;
    logic        reset;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        clear_req;
    logic        busy;
    logic [4:0]  rd_addr_a;
    logic [15:0] rd_data_a;
    logic [4:0]  rd_addr_b;
    logic [15:0] rd_data_b;

    int checks   = 0;
    int failures = 0;

    register_file_core dut (
        .clk       (clk),
        .reset     (reset),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .clear_req (clear_req),
        .busy      (busy),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Checker
    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [4:0] addr, input logic [15:0] data);
        wr_valid = 1'b1;
        wr_addr  = addr;
        wr_data  = data;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic check_all(input string tag, input logic [15:0] expected);
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i);
            rd_addr_b = 5'(31 - i);
            tick();
            check({tag, "_a"}, 32'(rd_data_a), 32'(expected));
            check({tag, "_b"}, 32'(rd_data_b), 32'(expected));
        end
    endtask

    task automatic wait_idle(input string tag, output int cycles);
        cycles = 0;
        while (busy && cycles < 100) begin
            tick();
            cycles++;
        end
        if (busy) check({tag, "_timeout"}, 32'(busy), 32'd0);
    endtask

    int cyc;

    initial begin
        reset     = 1'b1;
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        clear_req = 1'b0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        #1;
        check("reset_rd_a",     32'(rd_data_a), 32'h0);
        check("reset_rd_b",     32'(rd_data_b), 32'h0);
        check("reset_wr_ready", 32'(wr_ready),  32'h1);
        check("reset_busy",     32'(busy),      32'h0);
        tick();
        tick();
        reset = 1'b0;
        check_all("reset_array", 16'h0000);

        // Basic write then read
        check("wr_ready_idle", 32'(wr_ready), 32'h1);
        write_word(5'd7, 16'hBEEF);
        rd_addr_a = 5'd7;
        rd_addr_b = 5'd6;
        tick();
        check("write_read_a", 32'(rd_data_a), 32'hBEEF);
        check("write_read_b", 32'(rd_data_b), 32'h0);

        // Same-cycle write bypass on the top address
        wr_valid  = 1'b1;
        wr_addr   = 5'd31;
        wr_data   = 16'h1234;
        rd_addr_a = 5'd31;
        rd_addr_b = 5'd7;
        tick();
        wr_valid = 1'b0;
        check("bypass_a", 32'(rd_data_a), 32'h1234);
        check("bypass_b", 32'(rd_data_b), 32'hBEEF);

        // Asynchronous reset mid-cycle clears outputs at once
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_rd_a", 32'(rd_data_a), 32'h0);
        check("async_rst_rd_b", 32'(rd_data_b), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        rd_addr_a = 5'd31;
        rd_addr_b = 5'd7;
        tick();
        check("async_rst_r32", 32'(rd_data_a), 32'h0);
        check("async_rst_r8",  32'(rd_data_b), 32'h0);

        // Fill everything, then clear sweep
        for (int i = 0; i < 32; i++) write_word(5'(i), 16'hFFFF);
        check_all("fill", 16'hFFFF);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        check("clr_busy_start",  32'(busy),     32'h1);
        check("clr_ready_start", 32'(wr_ready), 32'h0);
        rd_addr_a = 5'd0;
        rd_addr_b = 5'd1;
        wr_valid  = 1'b1;
        wr_addr   = 5'd3;
        wr_data   = 16'hABCD;
        tick();
        check("clr_bypass_r1", 32'(rd_data_a), 32'h0);
        check("clr_pending_r2", 32'(rd_data_b), 32'hFFFF);
        rd_addr_b = 5'd3;
        wait_idle("clr", cyc);
        wr_valid = 1'b0;
        check("clr_busy_cycles", 32'(cyc + 1), 32'd32);
        check("clr_ready_end",   32'(wr_ready), 32'h1);
        check("clr_blocked_r4",  32'(rd_data_b), 32'h0);
        check_all("clr_array", 16'h0000);

        // Write together with clear_req
        write_word(5'd9, 16'h0909);
        wr_valid  = 1'b1;
        wr_addr   = 5'd0;
        wr_data   = 16'h5555;
        clear_req = 1'b1;
        rd_addr_a = 5'd0;
        rd_addr_b = 5'd9;
        tick();
        wr_valid  = 1'b0;
        clear_req = 1'b0;
        check("wrclr_read_a", 32'(rd_data_a), 32'h5555);
        check("wrclr_read_b", 32'(rd_data_b), 32'h0909);
        check("wrclr_busy",   32'(busy),      32'h1);
        wait_idle("wrclr", cyc);
        check("wrclr_cycles", 32'(cyc), 32'd32);
        tick();
        check("wrclr_after_a", 32'(rd_data_a), 32'h0);
        check("wrclr_after_b", 32'(rd_data_b), 32'h0);

        // Reset during a sweep
        write_word(5'd2,  16'h7777);
        write_word(5'd20, 16'h2020);
        rd_addr_a = 5'd20;
        rd_addr_b = 5'd2;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (10) tick();
        check("sweep_r21_held", 32'(rd_data_a), 32'h2020);
        check("sweep_r3_clear", 32'(rd_data_b), 32'h0);
        check("sweep_busy",     32'(busy),      32'h1);
        #3;
        reset = 1'b1;
        #1;
        check("rst_sweep_busy",  32'(busy),      32'h0);
        check("rst_sweep_ready", 32'(wr_ready),  32'h1);
        check("rst_sweep_rd_a",  32'(rd_data_a), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        check_all("rst_sweep_array", 16'h0000);
        check("post_rst_ready", 32'(wr_ready), 32'h1);
        wr_valid  = 1'b1;
        wr_addr   = 5'd2;
        wr_data   = 16'h0A0A;
        rd_addr_a = 5'd2;
        rd_addr_b = 5'd20;
        tick();
        wr_valid = 1'b0;
        check("post_rst_bypass", 32'(rd_data_a), 32'h0A0A);
        check("post_rst_r21",    32'(rd_data_b), 32'h0);
        tick();
        check("post_rst_stored", 32'(rd_data_a), 32'h0A0A);
        check("post_rst_busy",   32'(busy),      32'h0);

        // Final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
